// File: rtl/pixel_pack_encode.sv
// rtl/pixel_pack_encode.sv - packs 2-bit palette codes MSB-first into RAM words, one frame at a time
module pixel_pack_encode #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1200,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [1:0]        pix_code,
  input  logic              flush,
  output logic              pix_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              frame_done
);

  localparam int PPW    = WIDTH / 2;
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PPW - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t state, state_next;

  logic [SLOT_W-1:0] slot;
  logic [ADDR_W-1:0] word_cnt;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shreg_fill;
  logic              accept;
  logic              wr_full;
  logic              wr_flush;
  logic              wr_any;
  logic              wr_last;
  logic [WIDTH-1:0]  wr_word;

  // Partial word with the incoming code dropped into the current slot (slot 0 at the MSBs).
  always_comb begin
    shreg_fill = shreg;
    for (int k = 0; k < PPW; k++) begin
      if (slot == SLOT_W'(k)) begin
        shreg_fill[WIDTH-1-2*k -: 2] = pix_code;
      end
    end
  end

  // Next state, handshake and write decisions; frame_start overrides everything else.
  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    accept     = 1'b0;
    wr_full    = 1'b0;
    wr_flush   = 1'b0;
    if (frame_start) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          pix_ready = !flush;
          accept    = pix_valid && !flush;
          wr_full   = accept && (slot == SLOT_LAST);
          wr_flush  = flush && (slot != '0);
          if ((wr_full || wr_flush) && (word_cnt == WORD_LAST)) begin
            state_next = DONE;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  assign wr_any  = wr_full || wr_flush;
  assign wr_last = wr_any && (word_cnt == WORD_LAST);
  assign wr_word = wr_full ? shreg_fill : shreg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Packing datapath and registered RAM write port; address/data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot       <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      slot       <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      we         <= wr_any;
      frame_done <= wr_last;
      if (wr_any) begin
        waddr <= word_cnt;
        wdata <= wr_word;
        slot  <= '0;
        shreg <= '0;
        if (!wr_last) begin
          word_cnt <= word_cnt + ADDR_W'(1);
        end
      end else if (accept) begin
        slot  <= slot + SLOT_W'(1);
        shreg <= shreg_fill;
      end
    end
  end

endmodule
